// File: rtl/flopoco_fmul_pipe.sv
// Two-stage pipelined multiplier for FloPoCo-format floats {exc, sign, exp, frac}.
// Round-to-nearest-even; a single stall signal holds both stages under backpressure.
module flopoco_fmul_pipe #(
   parameter int WE = 4,
   parameter int WF = 5,
   parameter int ID = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WE+WF+2:0]  X,
   input  logic [WE+WF+2:0]  Y,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WE+WF+2:0]  R
);

   localparam int W  = WE + WF + 3;
   localparam int PW = 2 * (WF + 1);
   localparam int EW = WE + 2;
   localparam logic [EW-1:0] BIAS = EW'((1 << (WE - 1)) - 1);

   typedef enum logic [1:0] {
      EXC_ZERO   = 2'b00,
      EXC_NORMAL = 2'b01,
      EXC_INF    = 2'b10,
      EXC_NAN    = 2'b11
   } exc_t;

   exc_t            x_exc, y_exc, in_exc;
   logic            in_sign;
   logic [EW-1:0]   in_exp;
   logic [PW-1:0]   in_prod;

   logic            s1_valid, s2_valid;
   logic            s1_sign;
   exc_t            s1_exc;
   logic [EW-1:0]   s1_exp;
   logic [PW-1:0]   s1_prod;

   logic            advance;
   logic            norm, guard, sticky, rnd_up;
   logic [PW-2:0]   shifted;
   logic [WF-1:0]   frac_t, frac_r;
   logic [EW-1:0]   exp_n, exp_r;
   exc_t            res_exc;
   logic [W-1:0]    result;

   assign advance   = !(s2_valid && !out_ready);
   assign in_ready  = advance;
   assign out_valid = s2_valid;

   // Stage 1 inputs: exception decode, exponent sum with bias removed, significand product.
   always_comb begin
      x_exc   = exc_t'(X[W-1:W-2]);
      y_exc   = exc_t'(Y[W-1:W-2]);
      in_sign = X[W-3] ^ Y[W-3];
      if (x_exc == EXC_NAN || y_exc == EXC_NAN ||
          (x_exc == EXC_ZERO && y_exc == EXC_INF) ||
          (x_exc == EXC_INF && y_exc == EXC_ZERO))
         in_exc = EXC_NAN;
      else if (x_exc == EXC_INF || y_exc == EXC_INF)
         in_exc = EXC_INF;
      else if (x_exc == EXC_ZERO || y_exc == EXC_ZERO)
         in_exc = EXC_ZERO;
      else
         in_exc = EXC_NORMAL;
      in_exp  = EW'(X[WF+WE-1:WF]) + EW'(Y[WF+WE-1:WF]) - BIAS;
      in_prod = PW'({1'b1, X[WF-1:0]}) * PW'({1'b1, Y[WF-1:0]});
   end

   // Stage 2 inputs: normalise, round to nearest even, then classify the rounded exponent.
   always_comb begin
      norm    = s1_prod[PW-1];
      shifted = norm ? s1_prod[PW-2:0] : {s1_prod[PW-3:0], 1'b0};
      frac_t  = shifted[PW-2 -: WF];
      guard   = shifted[WF];
      sticky  = |shifted[WF-1:0];
      exp_n   = s1_exp + EW'(norm);
      rnd_up  = guard & (sticky | frac_t[0]);
      {exp_r, frac_r} = {exp_n, frac_t} + (EW + WF)'(rnd_up);
      res_exc = s1_exc;
      if (s1_exc == EXC_NORMAL) begin
         case (exp_r[EW-1:EW-2])
            2'b00:   res_exc = EXC_NORMAL;
            2'b01:   res_exc = EXC_INF;
            default: res_exc = EXC_ZERO;
         endcase
      end
      if (res_exc == EXC_NORMAL)
         result = {res_exc, s1_sign, exp_r[WE-1:0], frac_r};
      else
         result = {res_exc, s1_sign, {(WE + WF){1'b0}}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         R        <= '0;
      end else if (advance) begin
         s1_valid <= in_valid;
         s2_valid <= s1_valid;
         if (s1_valid)
            R <= result;
      end
   end

   // NOTE: payload registers carry no reset; the valid bits alone decide whether they matter.
   always_ff @(posedge clk) begin
      if (advance && in_valid) begin
         s1_sign <= in_sign;
         s1_exc  <= in_exc;
         s1_exp  <= in_exp;
         s1_prod <= in_prod;
      end
   end

endmodule

// File: tb/tb_flopoco_fmul_pipe.sv
// Scoreboard bench for flopoco_fmul_pipe (WE=4, WF=5): directed vectors, backpressure,
// mid-stream reset and back-to-back throughput.
module tb_flopoco_fmul_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [11:0] X, Y, R;

   typedef struct {
      logic [11:0] r;
      int          hs;
      bit          chk_lat;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   bit   bp_en = 1'b0;
   bit   prev_stall = 1'b0;
   logic [11:0] prev_r;

   flopoco_fmul_pipe #(.WE(4), .WF(5), .ID(1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .X(X), .Y(Y),
      .out_valid(out_valid), .out_ready(out_ready), .R(R)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Independent integer model: scale, normalise, round on the remainder.
   function automatic logic [11:0] fmul_model(input logic [11:0] x, input logic [11:0] y);
      logic [1:0] ex, ey;
      logic       s;
      int         p, e, sh, q, rem, half;
      ex = x[11:10];
      ey = y[11:10];
      s  = x[9] ^ y[9];
      if (ex == 2'd3 || ey == 2'd3 || (ex == 2'd0 && ey == 2'd2) || (ex == 2'd2 && ey == 2'd0))
         return {2'b11, s, 9'b0};
      if (ex == 2'd2 || ey == 2'd2) return {2'b10, s, 9'b0};
      if (ex == 2'd0 || ey == 2'd0) return {2'b00, s, 9'b0};
      p  = (32 + int'(x[4:0])) * (32 + int'(y[4:0]));
      e  = int'(x[8:5]) + int'(y[8:5]) - 7;
      sh = 5;
      if (p >= 2048) begin
         sh = 6;
         e++;
      end
      q    = p >> sh;
      rem  = p % (1 << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == 64) begin
         q = 32;
         e++;
      end
      if (e > 15) return {2'b10, s, 9'b0};
      if (e < 0)  return {2'b00, s, 9'b0};
      return {2'b01, s, 4'(e), 5'(q)};
   endfunction

   function automatic logic [11:0] rand_norm();
      return {2'b01, 1'($urandom), 4'($urandom_range(2, 12)), 5'($urandom)};
   endfunction

   task automatic send(input logic [11:0] x, input logic [11:0] y, input logic [11:0] r,
                       input bit push, input bit lat);
      int   w;
      int   hs;
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      X = x;
      Y = y;
      #1;
      w = 0;
      while (!in_ready && w < 200) begin
         @(negedge clk);
         #1;
         w++;
      end
      if (!in_ready) begin
         check("in_ready_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      hs = cyc;
      if (push) begin
         e.r = r;
         e.hs = hs;
         e.chk_lat = lat;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("drain_queue_empty", sb.size(), 0);
   endtask

   // Backpressure generator.
   initial forever begin
      @(negedge clk);
      if (bp_en) out_ready = 1'($urandom_range(0, 1));
   end

   // Monitor: pops the scoreboard on each output handshake, checks hold and in_ready rules.
   initial forever begin
      exp_t e;
      @(negedge clk);
      #2;
      if (rst) begin
         prev_stall = 1'b0;
         continue;
      end
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
         check("hold_out_valid", out_valid, 1);
         check("hold_R", R, prev_r);
      end
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            check("spurious_output", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            check("R", R, e.r);
            if (e.chk_lat) check("latency", cyc - e.hs, 2);
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_r = R;
   end

   initial begin
      logic [11:0] a, b;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      X = '0;
      Y = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_out_valid", out_valid, 0);
      check("reset_R", R, 12'h000);
      check("reset_in_ready", in_ready, 1);

      // Directed vectors with hand-computed products.
      send(12'h4F0, 12'h4F0, 12'h504, 1, 1);
      send(12'h4E3, 12'h4F0, 12'h4F4, 1, 1);
      send(12'h4E5, 12'h4F0, 12'h4F8, 1, 1);
      send(12'h5E0, 12'h5E0, 12'h800, 1, 1);
      send(12'h000, 12'h800, 12'hC00, 1, 1);
      send(12'h4E0, 12'h01F, 12'h000, 1, 1);
      send(12'h6F0, 12'h4F0, 12'h704, 1, 1);
      send(12'h400, 12'h400, 12'h000, 1, 1);
      send(12'h200, 12'h4F0, 12'h200, 1, 1);
      send(12'hC00, 12'h4F0, 12'hC00, 1, 1);
      send(12'h800, 12'h6F0, 12'hA00, 1, 1);
      wait_drain();

      // Backpressure stream.
      bp_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = rand_norm();
         b = rand_norm();
         send(a, b, fmul_model(a, b), 1, 0);
      end
      wait_drain();
      bp_en = 1'b0;
      @(negedge clk);
      out_ready = 1'b1;

      // Mid-stream reset with two operations in flight.
      @(negedge clk);
      out_ready = 1'b0;
      send(12'h4F0, 12'h5E0, 12'h000, 0, 0);
      send(12'h4E3, 12'h4E5, 12'h000, 0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      check("rst_flush_out_valid", out_valid, 0);
      check("rst_flush_R", R, 12'h000);
      repeat (3) @(negedge clk);
      send(12'h4F0, 12'h4F0, 12'h504, 1, 1);
      wait_drain();

      // Throughput: 16 back-to-back pairs, each must come out exactly 2 cycles later.
      for (int i = 0; i < 16; i++) begin
         a = rand_norm();
         b = rand_norm();
         send(a, b, fmul_model(a, b), 1, 1);
      end
      wait_drain();
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
